// File: rtl/aipp_pkg.sv
// Shared AIPP header layout, opcodes and scheduler state encoding.
package aipp_pkg;

    localparam logic [7:0] OP_PRECHARGE = 8'h10;
    localparam logic [7:0] OP_ABORT     = 8'h12;

    localparam int OPC_W   = 8;
    localparam int DLY_LSB = OPC_W;

    // Voltage follows the delay field, so its offset depends on DELAY_W.
    function automatic int volt_lsb(input int delay_w);
        return OPC_W + delay_w;
    endfunction

    function automatic int fld_end(input int delay_w, input int volt_w);
        return OPC_W + delay_w + volt_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        FIRE
    } state_t;

endpackage

// File: rtl/aipp_cmd_fifo.sv
// Synchronous FIFO with show-ahead read data; flush beats push and pop.
// Latency: pushed entry visible at the head one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module aipp_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_dat;
    end

    assign pop_dat = r_mem[r_rd_ptr];
    assign full    = (r_level == (AW+1)'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;

endmodule

// File: rtl/aipp_cmd_scheduler.sv
// Decodes AIPP headers, queues PRECHARGE commands and fires a VRM setpoint after each delay.
// Latency: header accepted at edge N -> trig_valid after edge N+1+delay*CYCLES_PER_US.
// Backpressure: hdr_ready drops while the queue is full; a trigger waits in FIRE for trig_ready.
module aipp_cmd_scheduler #(
    parameter int HDR_W         = 128,
    parameter int DELAY_W       = 32,
    parameter int VOLT_W        = 32,
    parameter int DEPTH         = 4,
    parameter int CYCLES_PER_US = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [HDR_W-1:0]         hdr_in,
    input  logic                     hdr_valid,
    output logic                     hdr_ready,
    output logic                     trig_valid,
    input  logic                     trig_ready,
    output logic [VOLT_W-1:0]        trig_voltage_mv,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_level,
    output logic [7:0]               drop_cnt
);

    import aipp_pkg::*;

    localparam int ENT_W   = DELAY_W + VOLT_W;
    localparam int CNT_W   = DELAY_W + $clog2(CYCLES_PER_US + 1);
    localparam int VLSB    = volt_lsb(DELAY_W);
    localparam int FLD_END = fld_end(DELAY_W, VOLT_W);
    localparam logic [CNT_W-1:0] CPU = CNT_W'(CYCLES_PER_US);

    if (HDR_W < FLD_END) begin : g_bad_hdr_w
        $error("aipp_cmd_scheduler: HDR_W too small for opcode, delay and voltage fields");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("aipp_cmd_scheduler: DEPTH must be a power of two >= 2");
    end
    if (CYCLES_PER_US < 1) begin : g_bad_cpu
        $error("aipp_cmd_scheduler: CYCLES_PER_US must be >= 1");
    end
    if (HDR_W > FLD_END) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^hdr_in[HDR_W-1:FLD_END];
    end

    logic [7:0]         w_opc;
    logic               w_acc;
    logic               w_push;
    logic               w_flush;
    logic               w_unknown;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENT_W-1:0]   w_head;
    logic [DELAY_W-1:0] w_head_dly;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cyc_cnt;
    logic [VOLT_W-1:0]  r_volt;
    logic [7:0]         r_drop_cnt;

    assign w_opc     = hdr_in[OPC_W-1:0];
    assign w_acc     = hdr_valid && hdr_ready;
    assign w_push    = w_acc && (w_opc == OP_PRECHARGE);
    assign w_flush   = w_acc && (w_opc == OP_ABORT);
    assign w_unknown = w_acc && (w_opc != OP_PRECHARGE) && (w_opc != OP_ABORT);

    aipp_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_push),
        .push_dat ({hdr_in[DLY_LSB +: DELAY_W], hdr_in[VLSB +: VOLT_W]}),
        .pop      (w_pop),
        .flush    (w_flush),
        .pop_dat  (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .level    (q_level)
    );

    assign w_head_dly = w_head[ENT_W-1 -: DELAY_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Abort overrides every state transition, including a FIRE handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        if (w_flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = (w_head_dly == '0) ? FIRE : COUNT;
                    end
                end
                COUNT:   if (r_cyc_cnt == '0) w_state_nxt = FIRE;
                FIRE:    if (trig_ready)      w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Product is formed at CNT_W so the largest delay cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt <= '0;
            r_volt    <= '0;
        end else if (w_pop) begin
            r_cyc_cnt <= (w_head_dly == '0) ? '0 : CNT_W'(w_head_dly) * CPU - CNT_W'(1);
            r_volt    <= w_head[VOLT_W-1:0];
        end else if (r_state == COUNT && r_cyc_cnt != '0) begin
            r_cyc_cnt <= r_cyc_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_drop_cnt <= '0;
        else if (w_unknown && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
    end

    assign hdr_ready       = !w_full;
    assign trig_valid      = (r_state == FIRE);
    assign trig_voltage_mv = r_volt;
    assign busy            = !w_empty || (r_state != IDLE);
    assign drop_cnt        = r_drop_cnt;

endmodule

// File: tb/tb_aipp_cmd_scheduler.sv
// Directed bench for aipp_cmd_scheduler with CYCLES_PER_US=4 and DEPTH=4.
module tb_aipp_cmd_scheduler;

    localparam int HDR_W = 128;
    localparam int DW    = 32;
    localparam int VW    = 32;
    localparam int DEPTH = 4;
    localparam int CPU   = 4;

    logic             clk;
    logic             rst_n;
    logic [HDR_W-1:0] hdr_in;
    logic             hdr_valid;
    logic             hdr_ready;
    logic             trig_valid;
    logic             trig_ready;
    logic [VW-1:0]    trig_voltage_mv;
    logic             busy;
    logic [2:0]       q_level;
    logic [7:0]       drop_cnt;

    int n_chk = 0;
    int n_err = 0;

    aipp_cmd_scheduler #(
        .HDR_W(HDR_W), .DELAY_W(DW), .VOLT_W(VW), .DEPTH(DEPTH), .CYCLES_PER_US(CPU)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hdr_in          (hdr_in),
        .hdr_valid       (hdr_valid),
        .hdr_ready       (hdr_ready),
        .trig_valid      (trig_valid),
        .trig_ready      (trig_ready),
        .trig_voltage_mv (trig_voltage_mv),
        .busy            (busy),
        .q_level         (q_level),
        .drop_cnt        (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [HDR_W-1:0] mk(input logic [7:0] opc, input logic [31:0] d,
                                             input logic [31:0] v);
        return {56'b0, v, d, opc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] opc, input logic [31:0] d, input logic [31:0] v);
        hdr_in    = mk(opc, d, v);
        hdr_valid = 1'b1;
        tick();
        hdr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int early;
        int k;
        int fired;
        logic acc;

        rst_n      = 1'b0;
        hdr_in     = '0;
        hdr_valid  = 1'b0;
        trig_ready = 1'b0;
        #22;
        chk("rst_hdr_ready", hdr_ready, 1);
        chk("rst_trig_valid", trig_valid, 0);
        chk("rst_volt", trig_voltage_mv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q_level", q_level, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Single trigger: delay 3us -> 12 cycles, valid after edge N+13.
        trig_ready = 1'b1;
        send(8'h10, 3, 900);
        chk("t1_busy", busy, 1);
        early = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (trig_valid) early++;
        end
        chk("t1_early", early, 0);
        tick();
        chk("t1_valid", trig_valid, 1);
        chk("t1_volt", trig_voltage_mv, 900);
        tick();
        chk("t1_drop_valid", trig_valid, 0);
        chk("t1_idle_busy", busy, 0);

        // Zero delay with trig_ready held low.
        trig_ready = 1'b0;
        send(8'h10, 0, 750);
        chk("t2_not_yet", trig_valid, 0);
        tick();
        chk("t2_valid", trig_valid, 1);
        chk("t2_volt", trig_voltage_mv, 750);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_hold_valid", trig_valid, 1);
            chk("t2_hold_volt", trig_voltage_mv, 750);
        end
        trig_ready = 1'b1;
        tick();
        chk("t2_after_hs", trig_valid, 0);

        // Full queue: 5 accepted (1 in FIRE + 4 queued), 6th stalls.
        trig_ready = 1'b0;
        for (k = 0; k < 5; k++) begin
            chk("t3_rdy", hdr_ready, 1);
            hdr_in    = mk(8'h10, 0, 1001 + k);
            hdr_valid = 1'b1;
            tick();
        end
        hdr_in = mk(8'h10, 0, 1006);
        chk("t3_full_rdy", hdr_ready, 0);
        chk("t3_full_lvl", q_level, 4);
        chk("t3_fire", trig_valid, 1);
        tick();
        tick();
        chk("t3_still_full", q_level, 4);
        trig_ready = 1'b1;
        fired = 0;
        for (int c = 0; c < 300 && fired < 6; c++) begin
            if (trig_valid) begin
                chk("t3_order", trig_voltage_mv, 1001 + fired);
                fired++;
            end
            acc = hdr_valid && hdr_ready;
            tick();
            if (acc) begin
                k++;
                hdr_valid = 1'b0;
            end
        end
        chk("t3_fired", fired, 6);
        chk("t3_accepted", k, 6);
        tick();
        chk("t3_empty_lvl", q_level, 0);
        chk("t3_empty_busy", busy, 0);

        // Abort while a trigger is being offered with trig_ready high.
        trig_ready = 1'b0;
        send(8'h10, 0, 2001);
        send(8'h10, 0, 2002);
        send(8'h10, 0, 2003);
        chk("t4_pre_valid", trig_valid, 1);
        chk("t4_pre_lvl", q_level, 2);
        hdr_in     = mk(8'h12, 0, 0);
        hdr_valid  = 1'b1;
        trig_ready = 1'b1;
        tick();
        hdr_valid = 1'b0;
        chk("t4_valid", trig_valid, 0);
        chk("t4_lvl", q_level, 0);
        chk("t4_busy", busy, 0);
        early = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (trig_valid) early++;
        end
        chk("t4_no_trig", early, 0);

        // Unknown opcodes saturate the drop counter.
        early     = 0;
        hdr_in    = mk(8'h55, 1, 123);
        hdr_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (trig_valid || q_level != 0) early++;
            if (i == 199) chk("t5_drop_200", drop_cnt, 200);
        end
        hdr_valid = 1'b0;
        chk("t5_drop_sat", drop_cnt, 255);
        chk("t5_quiet", early, 0);

        // Reset mid-COUNT, then a fresh command times from zero.
        send(8'h10, 5, 1234);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", trig_valid, 0);
        chk("t6_rst_rdy", hdr_ready, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_lvl", q_level, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        chk("t6_rst_volt", trig_voltage_mv, 0);
        #3;
        rst_n = 1'b1;
        tick();
        send(8'h10, 2, 555);
        early = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (trig_valid) early++;
        end
        chk("t6_early", early, 0);
        tick();
        chk("t6_valid", trig_valid, 1);
        chk("t6_volt", trig_voltage_mv, 555);
        tick();
        chk("t6_done", trig_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
